uart_mon_mem_engine: RTL and testbench



---
 rtl/uart_mon_pkg.sv | 21 ++
 rtl/mon_line_buffer.sv | 30 +++
 rtl/uart_mon_mem_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_mon_mem_engine.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the UART monitor memory engine.
// Imported by the line buffer and the engine top.
package uart_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RREQ,
        ST_RWAIT,
        ST_SEND,
        ST_FREQ,
        ST_FWAIT
    } mon_state_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

    function automatic int slot_width(input int wpl);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

endpackage

// File: rtl/mon_line_buffer.sv
// Capture register for one UART dump line of WPL 32-bit words.
// Clear has priority over a slot write in the same cycle.
module mon_line_buffer
    import uart_mon_pkg::*;
#(
    parameter int WPL    = 4,
    parameter int SLOT_W = slot_width(WPL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] slot,
    input  logic [31:0]       wr_data,
    output logic [32*WPL-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < WPL; i++) begin
                if (slot == SLOT_W'(i)) begin
                    data[32*i +: 32] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mon_mem_engine.sv
// Monitor memory engine: write counter, multi-word line dump and
// pattern range fill sharing one read port and one write port.
module uart_mon_mem_engine
    import uart_mon_pkg::*;
#(
    parameter int AWIDTH = 20,
    parameter int WPL    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       uart_data,
    input  logic              write_address_set,
    input  logic              write_data_en,
    input  logic              read_start_set,
    input  logic              read_end_set,
    input  logic              fill_start,
    input  logic              read_stop,
    output logic              mem_read_req,
    output logic [31:0]       mem_read_adr,
    input  logic              mem_read_valid,
    input  logic [31:0]       mem_read_data,
    output logic              mem_write_req,
    output logic [31:0]       mem_write_adr,
    output logic [31:0]       mem_write_data,
    input  logic              mem_write_finish,
    output logic              line_snd_start,
    output logic [32*WPL-1:0] line_snd_data,
    input  logic              line_snd_done,
    output logic              dump_running,
    output logic              fill_running,
    output logic              write_busy,
    output logic              write_overrun
);

    localparam int SLOT_W = slot_width(WPL);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WPL - 1);

    mon_state_e state_q, state_d;

    logic [AWIDTH:0]   ptr_q, ptr_d, end_ext;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [AWIDTH-1:0] start_q, end_q, wcnt_q, adr_in;
    logic [31:0]       pattern_q, wadr_q, wdata_q;
    logic              wreq_q, busy_q, overrun_q, snd_q;
    logic              buf_clear, buf_wr, fill_issue;
    logic              wr_accept, fill_act;

    function automatic logic [31:0] byte_adr(input logic [AWIDTH-1:0] a);
        logic [31:0] r;
        r = '0;
        r[AWIDTH+BYTE_SHIFT-1:BYTE_SHIFT] = a;
        return r;
    endfunction

    assign adr_in    = uart_data[AWIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
    assign end_ext   = {1'b0, end_q};
    assign fill_act  = (state_q == ST_FREQ) || (state_q == ST_FWAIT);
    assign wr_accept = write_data_en && !busy_q && !fill_act;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        buf_clear  = 1'b0;
        buf_wr     = 1'b0;
        fill_issue = 1'b0;
        if (state_q != ST_IDLE && read_stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (read_end_set) begin
                        if (start_q <= adr_in) begin
                            state_d   = ST_RREQ;
                            ptr_d     = {1'b0, start_q};
                            slot_d    = '0;
                            buf_clear = 1'b1;
                        end
                    end else if (fill_start && start_q <= end_q) begin
                        state_d = ST_FREQ;
                        ptr_d   = {1'b0, start_q};
                    end
                end
                ST_RREQ: state_d = ST_RWAIT;
                ST_RWAIT: begin
                    if (mem_read_valid) begin
                        buf_wr = 1'b1;
                        ptr_d  = ptr_q + 1'b1;
                        slot_d = slot_q + 1'b1;
                        if (slot_q == LAST_SLOT || ptr_q == end_ext) begin
                            state_d = ST_SEND;
                        end else begin
                            state_d = ST_RREQ;
                        end
                    end
                end
                ST_SEND: begin
                    if (line_snd_done) begin
                        if (ptr_q > end_ext) begin
                            state_d = ST_IDLE;
                        end else begin
                            buf_clear = 1'b1;
                            slot_d    = '0;
                            state_d   = ST_RREQ;
                        end
                    end
                end
                // A pending manual write holds the fill off the shared port.
                ST_FREQ: begin
                    if (!busy_q) begin
                        fill_issue = 1'b1;
                        state_d    = ST_FWAIT;
                    end
                end
                ST_FWAIT: begin
                    if (mem_write_finish) begin
                        ptr_d = ptr_q + 1'b1;
                        if (ptr_q == end_ext) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FREQ;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            slot_q  <= '0;
            snd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            snd_q   <= (state_d == ST_SEND) && (state_q != ST_SEND);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= '0;
            end_q     <= '0;
            pattern_q <= '0;
        end else begin
            if (read_start_set) begin
                start_q <= adr_in;
            end
            if (state_q == ST_IDLE) begin
                if (read_end_set) begin
                    end_q <= adr_in;
                end else if (fill_start) begin
                    pattern_q <= uart_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wreq_q    <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            wreq_q <= 1'b0;
            if (wr_accept) begin
                wreq_q  <= 1'b1;
                wadr_q  <= byte_adr(wcnt_q);
                wdata_q <= uart_data;
                busy_q  <= 1'b1;
            end else begin
                if (fill_issue) begin
                    wreq_q  <= 1'b1;
                    wadr_q  <= byte_adr(ptr_q[AWIDTH-1:0]);
                    wdata_q <= pattern_q;
                end
                if (busy_q && mem_write_finish) begin
                    busy_q <= 1'b0;
                end
            end
            if (write_address_set) begin
                wcnt_q <= adr_in;
            end else if (wr_accept) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            if (write_data_en && !wr_accept) begin
                overrun_q <= 1'b1;
            end else if (write_address_set) begin
                overrun_q <= 1'b0;
            end
        end
    end

    mon_line_buffer #(
        .WPL    (WPL),
        .SLOT_W (SLOT_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .slot    (slot_q),
        .wr_data (mem_read_data),
        .data    (line_snd_data)
    );

    assign mem_read_req   = (state_q == ST_RREQ);
    assign mem_read_adr   = byte_adr(ptr_q[AWIDTH-1:0]);
    assign mem_write_req  = wreq_q;
    assign mem_write_adr  = wadr_q;
    assign mem_write_data = wdata_q;
    assign line_snd_start = snd_q;
    assign dump_running   = (state_q == ST_RREQ) || (state_q == ST_RWAIT)
                          || (state_q == ST_SEND);
    assign fill_running   = fill_act;
    assign write_busy     = busy_q;
    assign write_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_mon_mem_engine.sv
// Directed bench for uart_mon_mem_engine with memory and UART
// sender responders; expected values are hand-computed constants.
module tb_uart_mon_mem_engine;

    localparam int AW = 20;
    localparam int WPL = 4;
    localparam int LW = 32 * WPL;

    typedef enum {C_WA, C_WE, C_RS, C_RE, C_FILL, C_STOP} cmd_e;

    logic          clk;
    logic          rst;
    logic [31:0]   uart_data;
    logic          write_address_set, write_data_en;
    logic          read_start_set, read_end_set;
    logic          fill_start, read_stop;
    logic          mem_read_req, mem_read_valid;
    logic [31:0]   mem_read_adr, mem_read_data;
    logic          mem_write_req, mem_write_finish;
    logic [31:0]   mem_write_adr, mem_write_data;
    logic          line_snd_start, line_snd_done;
    logic [LW-1:0] line_snd_data;
    logic          dump_running, fill_running, write_busy, write_overrun;

    int checks = 0;
    int failures = 0;
    int rd_lat = 1;
    int rd_count = 0;
    int stab_bad = 0;
    logic [31:0]   rd_a;
    logic          prev_valid;
    logic [31:0]   wadr_log[$];
    logic [31:0]   wdat_log[$];
    logic [LW-1:0] lines[$];
    logic          lat_ok[$];

    uart_mon_mem_engine #(.AWIDTH(AW), .WPL(WPL)) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_data         (uart_data),
        .write_address_set (write_address_set),
        .write_data_en     (write_data_en),
        .read_start_set    (read_start_set),
        .read_end_set      (read_end_set),
        .fill_start        (fill_start),
        .read_stop         (read_stop),
        .mem_read_req      (mem_read_req),
        .mem_read_adr      (mem_read_adr),
        .mem_read_valid    (mem_read_valid),
        .mem_read_data     (mem_read_data),
        .mem_write_req     (mem_write_req),
        .mem_write_adr     (mem_write_adr),
        .mem_write_data    (mem_write_data),
        .mem_write_finish  (mem_write_finish),
        .line_snd_start    (line_snd_start),
        .line_snd_data     (line_snd_data),
        .line_snd_done     (line_snd_done),
        .dump_running      (dump_running),
        .fill_running      (fill_running),
        .write_busy        (write_busy),
        .write_overrun     (write_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) prev_valid <= mem_read_valid;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input cmd_e c, input logic [31:0] d);
        uart_data = d;
        case (c)
            C_WA:    write_address_set = 1'b1;
            C_WE:    write_data_en = 1'b1;
            C_RS:    read_start_set = 1'b1;
            C_RE:    read_end_set = 1'b1;
            C_FILL:  fill_start = 1'b1;
            default: read_stop = 1'b1;
        endcase
        step();
        write_address_set = 1'b0;
        write_data_en = 1'b0;
        read_start_set = 1'b0;
        read_end_set = 1'b0;
        fill_start = 1'b0;
        read_stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((dump_running || fill_running || write_busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, {dump_running, fill_running, write_busy}, 3'b000);
    endtask

    // Read memory: data = 0xC0DE0000 + byte address, rd_lat cycles after req.
    initial begin
        mem_read_valid = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (mem_read_req) begin
                rd_a = mem_read_adr;
                rd_count++;
                repeat (rd_lat) @(posedge clk);
                #1;
                mem_read_valid = 1'b1;
                mem_read_data = 32'hC0DE_0000 + rd_a;
                @(posedge clk);
                #1;
                mem_read_valid = 1'b0;
            end
        end
    end

    // Write memory: logs each request, finish two cycles later.
    initial begin
        mem_write_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_write_req) begin
                wadr_log.push_back(mem_write_adr);
                wdat_log.push_back(mem_write_data);
                @(posedge clk);
                @(posedge clk);
                #1;
                mem_write_finish = 1'b1;
                @(posedge clk);
                #1;
                mem_write_finish = 1'b0;
            end
        end
    end

    // UART sender: captures line, done a few cycles later.
    initial begin
        line_snd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (line_snd_start) begin
                lines.push_back(line_snd_data);
                lat_ok.push_back(prev_valid);
                repeat (3) @(posedge clk);
                #1;
                if (line_snd_data !== lines[lines.size()-1]) stab_bad++;
                line_snd_done = 1'b1;
                @(posedge clk);
                #1;
                line_snd_done = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        uart_data = '0;
        write_address_set = 1'b0;
        write_data_en = 1'b0;
        read_start_set = 1'b0;
        read_end_set = 1'b0;
        fill_start = 1'b0;
        read_stop = 1'b0;
        repeat (3) step();
        chk("rst_req", {mem_read_req, mem_write_req, line_snd_start}, 3'b000);
        chk("rst_status", {dump_running, fill_running, write_busy, write_overrun}, 4'h0);
        chk("rst_radr", mem_read_adr, 32'h0);
        chk("rst_wadr", {mem_write_adr, mem_write_data}, 64'h0);
        chk("rst_line", line_snd_data, '0);
        rst = 1'b0;
        step();

        cmd(C_WA, 32'h100);
        cmd(C_WE, 32'h1111_1111);
        wait_idle("w0", 50);
        cmd(C_WE, 32'h2222_2222);
        wait_idle("w1", 50);
        cmd(C_WE, 32'h3333_3333);
        wait_idle("w2", 50);
        chk("w_count", wadr_log.size(), 3);
        chk("w_adr0", wadr_log[0], 32'h100);
        chk("w_adr1", wadr_log[1], 32'h104);
        chk("w_adr2", wadr_log[2], 32'h108);
        chk("w_dat2", wdat_log[2], 32'h3333_3333);
        chk("w_ovr0", write_overrun, 1'b0);

        wadr_log.delete();
        wdat_log.delete();
        write_data_en = 1'b1;
        uart_data = 32'hAAAA_0001;
        step();
        uart_data = 32'hAAAA_0002;
        step();
        write_data_en = 1'b0;
        chk("ovr_set", write_overrun, 1'b1);
        wait_idle("ovr", 50);
        chk("ovr_count", wadr_log.size(), 1);
        chk("ovr_adr", wadr_log[0], 32'h10C);
        chk("ovr_dat", wdat_log[0], 32'hAAAA_0001);
        cmd(C_WA, 32'h003F_FFFC);
        chk("ovr_clr", write_overrun, 1'b0);
        cmd(C_WE, 32'h77);
        wait_idle("wrap0", 50);
        cmd(C_WE, 32'h88);
        wait_idle("wrap1", 50);
        chk("wrap_top", wadr_log[1], 32'h003F_FFFC);
        chk("wrap_zero", wadr_log[2], 32'h0);

        lines.delete();
        lat_ok.delete();
        cmd(C_RS, 32'h0);
        cmd(C_RE, 32'h18);
        wait_idle("d7", 400);
        chk("d7_lines", lines.size(), 2);
        chk("d7_line0", lines[0], {32'hC0DE_000C, 32'hC0DE_0008,
                                  32'hC0DE_0004, 32'hC0DE_0000});
        chk("d7_line1", lines[1], {32'h0, 32'hC0DE_0018,
                                  32'hC0DE_0014, 32'hC0DE_0010});
        chk("d7_lat", lat_ok[0], 1'b1);

        lines.delete();
        rd_count = 0;
        cmd(C_RS, 32'h003F_FFFC);
        cmd(C_RE, 32'h003F_FFFC);
        wait_idle("top", 200);
        chk("top_lines", lines.size(), 1);
        chk("top_line0", lines[0], {96'h0, 32'hC11D_FFFC});
        chk("top_reads", rd_count, 1);

        cmd(C_RS, 32'h20);
        cmd(C_RE, 32'h10);
        chk("rev_idle", dump_running, 1'b0);
        step();
        chk("rev_noreq", mem_read_req, 1'b0);

        lines.delete();
        cmd(C_RS, 32'h40);
        cmd(C_RE, 32'h4C);
        wait_idle("d4", 200);
        chk("d4_line0", lines[0], {32'hC0DE_004C, 32'hC0DE_0048,
                                  32'hC0DE_0044, 32'hC0DE_0040});
        wadr_log.delete();
        wdat_log.delete();
        cmd(C_FILL, 32'hDEAD_BEEF);
        chk("fill_run", fill_running, 1'b1);
        cmd(C_WE, 32'h1234_5678);
        chk("fill_ovr", write_overrun, 1'b1);
        wait_idle("fill", 200);
        chk("fill_count", wadr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("fill_adr", wadr_log[i], 32'h40 + 32'(4 * i));
            chk("fill_dat", wdat_log[i], 32'hDEAD_BEEF);
        end
        chk("fill_done", fill_running, 1'b0);

        rd_lat = 6;
        lines.delete();
        cmd(C_RS, 32'h0);
        cmd(C_RE, 32'h8);
        step();
        step();
        chk("stop_run", dump_running, 1'b1);
        chk("stop_rwait", mem_read_req, 1'b0);
        cmd(C_STOP, 32'h0);
        chk("stop_idle", dump_running, 1'b0);
        repeat (12) step();
        chk("stop_nolines", lines.size(), 0);
        chk("stop_still", dump_running, 1'b0);
        rd_lat = 1;

        cmd(C_RS, 32'h0);
        cmd(C_RE, 32'h18);
        repeat (3) step();
        chk("rstm_run", dump_running, 1'b1);
        rst = 1'b1;
        step();
        chk("rstm_req", {mem_read_req, mem_write_req, line_snd_start}, 3'b000);
        chk("rstm_status", {dump_running, fill_running, write_busy, write_overrun}, 4'h0);
        chk("rstm_line", line_snd_data, '0);
        chk("rstm_adr", {mem_read_adr, mem_write_adr, mem_write_data}, 96'h0);
        rst = 1'b0;
        repeat (10) step();
        chk("rstm_idle", dump_running, 1'b0);
        chk("line_stable", stab_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
